// File: rtl/mac_acc_drain.sv
// mac_acc_drain: snapshots the four accumulator lanes on capture and drains them as framed beats.
// Defining MAC_DRAIN_DROP_CNT_EN builds the sticky drop flag and saturating lost-capture counter.

`ifndef MAC_SINGLE
`define MAC_SINGLE 2'd0
`endif
`ifndef MAC_DUAL
`define MAC_DUAL 2'd1
`endif
`ifndef MAC_QUAD
`define MAC_QUAD 2'd2
`endif

module mac_acc_drain #(
    parameter int MAC_MIN_WIDTH = 8,
    parameter int MAC_ACC_WIDTH = 4 * MAC_MIN_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               mode,
    input  logic                     capture,
    input  logic [MAC_ACC_WIDTH-1:0] in0,
    input  logic [MAC_ACC_WIDTH-1:0] in1,
    input  logic [MAC_ACC_WIDTH-1:0] in2,
    input  logic [MAC_ACC_WIDTH-1:0] in3,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [MAC_ACC_WIDTH-1:0] out_data,
    output logic [1:0]               out_id,
    output logic                     out_last,
    output logic                     out_end,
    output logic                     drop,
    output logic [7:0]               drop_cnt
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                   state_q, state_d;
    logic [1:0]               beat_q, beat_d;
    logic [1:0]               mode_q, mode_d;
    logic [MAC_ACC_WIDTH-1:0] snap_q [4];
    logic [MAC_ACC_WIDTH-1:0] snap_d [4];

    logic beatFire;
    logic frameDone;
    logic acceptCap;

    assign beatFire  = (state_q == SEND) && out_ready;
    assign frameDone = beatFire && (beat_q == 2'd3);
    assign acceptCap = capture && ((state_q == IDLE) || frameDone);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= 2'd0;
            mode_q  <= `MAC_SINGLE;
            for (int i = 0; i < 4; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            mode_q  <= mode_d;
            snap_q  <= snap_d;
        end
    end

    // A capture landing on the final-beat handshake reloads directly, keeping the stream gapless.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        mode_d  = mode_q;
        snap_d  = snap_q;
        if (acceptCap) begin
            snap_d[0] = in0;
            snap_d[1] = in1;
            snap_d[2] = in2;
            snap_d[3] = in3;
            case (mode)
                `MAC_DUAL: mode_d = `MAC_DUAL;
                `MAC_QUAD: mode_d = `MAC_QUAD;
                default:   mode_d = `MAC_SINGLE;
            endcase
            beat_d  = 2'd0;
            state_d = SEND;
        end else if (frameDone) begin
            beat_d  = 2'd0;
            state_d = IDLE;
        end else if (beatFire) begin
            beat_d = beat_q + 2'd1;
        end
    end

    always_comb begin
        busy      = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_id    = 2'd0;
        out_last  = 1'b0;
        out_end   = 1'b0;
        if (state_q == SEND) begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_data  = snap_q[beat_q];
            out_end   = (beat_q == 2'd3);
            case (mode_q)
                `MAC_DUAL: begin
                    out_id   = {1'b0, beat_q[1]};
                    out_last = beat_q[0];
                end
                `MAC_QUAD: begin
                    out_id   = 2'd0;
                    out_last = (beat_q == 2'd3);
                end
                default: begin
                    out_id   = beat_q;
                    out_last = 1'b1;
                end
            endcase
        end
    end

`ifdef MAC_DRAIN_DROP_CNT_EN
    logic       lostCap;
    logic       drop_q, drop_d;
    logic [7:0] dropCnt_q, dropCnt_d;

    assign lostCap = capture && (state_q == SEND) && !frameDone;

    always_comb begin
        drop_d    = drop_q;
        dropCnt_d = dropCnt_q;
        if (lostCap) begin
            drop_d = 1'b1;
            if (dropCnt_q != 8'hFF) begin
                dropCnt_d = dropCnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q    <= 1'b0;
            dropCnt_q <= 8'd0;
        end else begin
            drop_q    <= drop_d;
            dropCnt_q <= dropCnt_d;
        end
    end

    assign drop     = drop_q;
    assign drop_cnt = dropCnt_q;
`else
    assign drop     = 1'b0;
    assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_mac_acc_drain.sv
// Randomized self-checking bench for mac_acc_drain: a queue-of-beats model checked every cycle,
// plus directed frames with literal expectations.

`ifndef MAC_SINGLE
`define MAC_SINGLE 2'd0
`endif
`ifndef MAC_DUAL
`define MAC_DUAL 2'd1
`endif
`ifndef MAC_QUAD
`define MAC_QUAD 2'd2
`endif

module tb_mac_acc_drain;

    logic        clk;
    logic        rst_n;
    logic [1:0]  mode;
    logic        capture;
    logic [31:0] in0, in1, in2, in3;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_id;
    logic        out_last;
    logic        out_end;
    logic        drop;
    logic [7:0]  drop_cnt;

    mac_acc_drain dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .capture   (capture),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_last  (out_last),
        .out_end   (out_end),
        .drop      (drop),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  id;
        logic        last;
        logic        fin;
    } beat_t;

    beat_t       expQ[$];
    logic        expDrop;
    logic [7:0]  expCnt;
    int          passCount = 0;
    int          totalCount = 0;

    logic [1:0]  wantDrop1;
    logic [7:0]  wantCnt1;
    logic [7:0]  wantCntSat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Each accepted capture becomes four expected beats, framed by the lane-fusion mode.
    task automatic pushFrame(input logic [1:0] m, input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] a2, input logic [31:0] a3);
        logic [31:0] lanes [4];
        beat_t b;
        lanes[0] = a0; lanes[1] = a1; lanes[2] = a2; lanes[3] = a3;
        for (int k = 0; k < 4; k++) begin
            b.data = lanes[k];
            b.fin  = (k == 3);
            if (m == `MAC_DUAL) begin
                b.id   = 2'(k / 2);
                b.last = (k % 2 == 1);
            end else if (m == `MAC_QUAD) begin
                b.id   = 2'd0;
                b.last = (k == 3);
            end else begin
                b.id   = 2'(k);
                b.last = 1'b1;
            end
            expQ.push_back(b);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expQ.delete();
            expDrop = 1'b0;
            expCnt  = 8'd0;
        end else begin
            automatic bit hs     = (expQ.size() != 0) && out_ready;
            automatic bit lastHs = hs && (expQ.size() == 1);
            automatic bit acc    = capture && ((expQ.size() == 0) || lastHs);
`ifdef MAC_DRAIN_DROP_CNT_EN
            if (capture && !acc) begin
                expDrop = 1'b1;
                if (expCnt < 8'd255) expCnt = expCnt + 8'd1;
            end
`endif
            if (hs) void'(expQ.pop_front());
            if (acc) pushFrame(mode, in0, in1, in2, in3);
        end
    end

    always @(negedge clk) begin
        check("valid", {31'd0, out_valid}, {31'd0, expQ.size() != 0});
        check("busy", {31'd0, busy}, {31'd0, expQ.size() != 0});
        if (expQ.size() != 0) begin
            check("data", out_data, expQ[0].data);
            check("id", {30'd0, out_id}, {30'd0, expQ[0].id});
            check("last", {31'd0, out_last}, {31'd0, expQ[0].last});
            check("end", {31'd0, out_end}, {31'd0, expQ[0].fin});
        end
        if (!rst_n) begin
            check("rst_data", out_data, 32'd0);
            check("rst_id", {30'd0, out_id}, 32'd0);
            check("rst_last", {31'd0, out_last}, 32'd0);
            check("rst_end", {31'd0, out_end}, 32'd0);
        end
        check("drop", {31'd0, drop}, {31'd0, expDrop});
        check("drop_cnt", {24'd0, drop_cnt}, {24'd0, expCnt});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] a2, input logic [31:0] a3, input logic cap);
        mode = m; in0 = a0; in1 = a1; in2 = a2; in3 = a3; capture = cap;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] d, input logic [1:0] id,
                               input logic last, input logic fin);
        check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({name, "_data"}, out_data, d);
        check({name, "_id"}, {30'd0, out_id}, {30'd0, id});
        check({name, "_last"}, {31'd0, out_last}, {31'd0, last});
        check({name, "_end"}, {31'd0, out_end}, {31'd0, fin});
    endtask

    task automatic literalFrame(input string name, input logic [1:0] m, input logic [7:0] ids,
                                input logic [3:0] lasts);
        out_ready = 1'b1;
        applyStimulus(m, 32'h11, 32'h22, 32'h33, 32'h44, 1'b1);
        tick();
        capture = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput(name, 32'h11 * (k + 1), ids[2*k +: 2], lasts[k], k == 3);
            tick();
        end
        check({name, "_busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
`ifdef MAC_DRAIN_DROP_CNT_EN
        wantDrop1 = 2'd1; wantCnt1 = 8'd1; wantCntSat = 8'd255;
`else
        wantDrop1 = 2'd0; wantCnt1 = 8'd0; wantCntSat = 8'd0;
`endif
        rst_n = 1'b0;
        out_ready = 1'b0;
        applyStimulus(`MAC_SINGLE, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_dropcnt", {24'd0, drop_cnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        literalFrame("single", `MAC_SINGLE, 8'b11_10_01_00, 4'b1111);
        literalFrame("dual", `MAC_DUAL, 8'b01_01_00_00, 4'b1010);
        literalFrame("quad", `MAC_QUAD, 8'b00_00_00_00, 4'b1000);

        // Backpressure at beat 1 with the inputs scribbled over.
        out_ready = 1'b1;
        applyStimulus(`MAC_QUAD, 32'h55, 32'h66, 32'h77, 32'h88, 1'b1);
        tick();
        capture = 1'b0;
        tick();
        out_ready = 1'b0;
        applyStimulus(`MAC_SINGLE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold", out_data, 32'h66);
        end
        out_ready = 1'b1;
        tick();
        checkOutput("bp_b2", 32'h77, 2'd0, 1'b0, 1'b0);
        tick();
        checkOutput("bp_b3", 32'h88, 2'd0, 1'b1, 1'b1);
        tick();

        // Back-to-back reload on the final-beat handshake.
        applyStimulus(`MAC_SINGLE, 32'h11, 32'h22, 32'h33, 32'h44, 1'b1);
        tick();
        capture = 1'b0;
        repeat (3) tick();
        applyStimulus(`MAC_SINGLE, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 1'b1);
        tick();
        capture = 1'b0;
        checkOutput("b2b_b0", 32'hA0, 2'd0, 1'b1, 1'b0);
        repeat (4) tick();

        // Single lost capture during beat 1.
        applyStimulus(`MAC_QUAD, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 1'b1);
        tick();
        capture = 1'b0;
        tick();
        capture = 1'b1;
        tick();
        capture = 1'b0;
        check("lost_drop", {31'd0, drop}, {30'd0, wantDrop1});
        check("lost_cnt", {24'd0, drop_cnt}, {24'd0, wantCnt1});
        checkOutput("lost_b2", 32'hC2, 2'd0, 1'b0, 1'b0);
        repeat (3) tick();

        // Saturation of the lost-capture counter.
        out_ready = 1'b0;
        capture = 1'b1;
        tick();
        repeat (300) tick();
        capture = 1'b0;
        check("sat_cnt", {24'd0, drop_cnt}, {24'd0, wantCntSat});
        out_ready = 1'b1;
        repeat (5) tick();

        // Reset mid-frame at beat 2, then a fresh frame on the first edge after release.
        applyStimulus(`MAC_SINGLE, 32'h11, 32'h22, 32'h33, 32'h44, 1'b1);
        tick();
        capture = 1'b0;
        repeat (2) tick();
        checkOutput("prerst_b2", 32'h33, 2'd2, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_drop", {31'd0, drop}, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        applyStimulus(`MAC_DUAL, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 1'b1);
        tick();
        capture = 1'b0;
        checkOutput("postrst_b0", 32'hB0, 2'd0, 1'b0, 1'b0);
        repeat (4) tick();

        // Randomized traffic, including the unused mode encoding.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
                          $urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        capture = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
